// File: rtl/vga_axil_pkg.sv
// vga_axil_pkg: shared types and defaults for the VGA AXI4-Lite to native-port bridge.
//   axil_*_t      : AXI-Lite address/data/strobe types at the default widths
//   native_addr_t : native word address at the default depth
//   axil_resp_t   : AXI response codes used by the bridge
//   rd_state_t    : read-channel FSM states
package vga_axil_pkg;

    localparam int AXIL_ADDR_W_DEF  = 32;
    localparam int AXIL_DATA_W_DEF  = 32;
    localparam int NATIVE_DEPTH_DEF = 1024;
    localparam int NATIVE_ADDR_W    = $clog2(NATIVE_DEPTH_DEF);

    typedef logic [AXIL_ADDR_W_DEF-1:0]   axil_addr_t;
    typedef logic [AXIL_DATA_W_DEF-1:0]   axil_data_t;
    typedef logic [AXIL_DATA_W_DEF/8-1:0] axil_strb_t;
    typedef logic [NATIVE_ADDR_W-1:0]     native_addr_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axil_resp_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/vga_axil_addr_decode.sv
// vga_axil_addr_decode: byte address to native word address plus legality flag.
//   addr        : AXI-Lite byte address
//   native_addr : word address (addr >> 2) truncated to the native width
//   legal       : word aligned and inside the native depth
module vga_axil_addr_decode #(
    parameter  int AW    = 32,
    parameter  int DEPTH = 1024,
    localparam int NAW   = $clog2(DEPTH)
) (
    input  logic [AW-1:0]  addr,
    output logic [NAW-1:0] native_addr,
    output logic           legal
);

    logic [AW-1:0] word;

    assign word        = addr >> 2;
    assign native_addr = word[NAW-1:0];
    assign legal       = (addr[1:0] == 2'b00) && (word < AW'(DEPTH));

endmodule

// File: rtl/vga_axil2native.sv
// vga_axil2native: AXI4-Lite slave terminating the CPU bus onto the VGA native register/memory port.
//   clk, arst_n                        : clock, asynchronous active-low reset
//   aw*/w*/b*                          : AXI-Lite write address, data and response channels
//   ar*/r*                             : AXI-Lite read address and data channels
//   addr_write, data2native, write_en  : native single-cycle write strobe
//   addr_read, read_en_sync, data2axil : native synchronous read (data one clock after strobe)
module vga_axil2native
    import vga_axil_pkg::*;
#(
    parameter  int AXIL_ADDR_W  = AXIL_ADDR_W_DEF,
    parameter  int AXIL_DATA_W  = AXIL_DATA_W_DEF,
    parameter  int NATIVE_DEPTH = NATIVE_DEPTH_DEF,
    localparam int NAW          = $clog2(NATIVE_DEPTH),
    localparam int SW           = AXIL_DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [AXIL_ADDR_W-1:0] awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [AXIL_DATA_W-1:0] wdata,
    input  logic [SW-1:0]          wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [AXIL_ADDR_W-1:0] araddr,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [AXIL_DATA_W-1:0] rdata,
    output logic [1:0]             rresp,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [NAW-1:0]         addr_write,
    output logic [AXIL_DATA_W-1:0] data2native,
    output logic                   write_en,
    output logic [NAW-1:0]         addr_read,
    output logic                   read_en_sync,
    input  logic [AXIL_DATA_W-1:0] data2axil
);

    logic                   aw_full;
    logic                   w_full;
    logic [AXIL_ADDR_W-1:0] aw_addr_q;
    logic [AXIL_DATA_W-1:0] w_data_q;
    logic [SW-1:0]          w_strb_q;
    logic                   aw_hs;
    logic                   w_hs;
    logic [AXIL_ADDR_W-1:0] wr_addr;
    logic [AXIL_DATA_W-1:0] wr_data;
    logic [SW-1:0]          wr_strb;
    logic [NAW-1:0]         wr_na;
    logic                   wr_legal;
    logic                   wr_fire;
    logic                   wr_ok;
    rd_state_t              r_state;
    logic                   r_legal;
    logic [NAW-1:0]         rd_na;
    logic                   rd_legal;

    assign awready = !aw_full && !bvalid;
    assign wready  = !w_full && !bvalid;
    assign arready = (r_state == R_IDLE);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // Bypass the holding registers so the completing handshake issues the
    // native write on the very next edge rather than one cycle later.
    assign wr_addr = aw_full ? aw_addr_q : awaddr;
    assign wr_data = w_full ? w_data_q : wdata;
    assign wr_strb = w_full ? w_strb_q : wstrb;
    assign wr_fire = (aw_full || aw_hs) && (w_full || w_hs) && !bvalid;
    // Partial strobes are rejected: the native port has no byte enables.
    assign wr_ok   = wr_legal && (&wr_strb);

    vga_axil_addr_decode #(.AW(AXIL_ADDR_W), .DEPTH(NATIVE_DEPTH)) u_wr_dec (
        .addr        (wr_addr),
        .native_addr (wr_na),
        .legal       (wr_legal)
    );

    vga_axil_addr_decode #(.AW(AXIL_ADDR_W), .DEPTH(NATIVE_DEPTH)) u_rd_dec (
        .addr        (araddr),
        .native_addr (rd_na),
        .legal       (rd_legal)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bvalid      <= 1'b0;
            bresp       <= OKAY;
            write_en    <= 1'b0;
            addr_write  <= '0;
            data2native <= '0;
        end else begin
            write_en <= wr_fire && wr_ok;
            if (wr_fire) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_ok ? OKAY : SLVERR;
                if (wr_ok) begin
                    addr_write  <= wr_na;
                    data2native <= wr_data;
                end
            end else begin
                if (aw_hs) begin
                    aw_full   <= 1'b1;
                    aw_addr_q <= awaddr;
                end
                if (w_hs) begin
                    w_full   <= 1'b1;
                    w_data_q <= wdata;
                    w_strb_q <= wstrb;
                end
            end
            if (bvalid && bready) bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= R_IDLE;
            r_legal      <= 1'b0;
            addr_read    <= '0;
            read_en_sync <= 1'b0;
            rdata        <= '0;
            rresp        <= OKAY;
            rvalid       <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_state      <= R_READ;
                        r_legal      <= rd_legal;
                        addr_read    <= rd_na;
                        read_en_sync <= rd_legal;
                    end
                end
                R_READ: begin
                    read_en_sync <= 1'b0;
                    rdata        <= r_legal ? data2axil : '0;
                    rresp        <= r_legal ? OKAY : SLVERR;
                    rvalid       <= 1'b1;
                    r_state      <= R_RESP;
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
